// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer slice: opcode constants, FSM
// state encoding, status bit positions, register-file geometry and the
// latched-instruction record.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    // Register file geometry
    localparam int REG_COUNT = 4;
    localparam int REG_WIDTH = 8;

    // ALU function codes; 1010-1110 are unused and treated as illegal
    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_SUB     = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_NOT     = 4'b0101;
    localparam logic [3:0] OP_PASSB   = 4'b0110;
    localparam logic [3:0] OP_LSR     = 4'b0111;
    localparam logic [3:0] OP_LSL     = 4'b1000;
    localparam logic [3:0] OP_SET_ALL = 4'b1001;
    localparam logic [3:0] OP_LOADI   = 4'b1111;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    // Bit positions inside the status word {overflow, carry, neg, zero}
    localparam int STATUS_ZERO  = 0;
    localparam int STATUS_NEG   = 1;
    localparam int STATUS_CARRY = 2;
    localparam int STATUS_OVF   = 3;

    // Everything captured when an instruction is accepted
    typedef struct packed {
        logic [3:0]           op;
        logic [1:0]           rd;
        logic [2:0]           shift;
        logic [REG_WIDTH-1:0] a;
        logic [REG_WIDTH-1:0] b;
        logic [REG_WIDTH-1:0] imm;
    } instr_t;

    // True for codes that go through the external ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_SET_ALL;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// 4 x 8 general register file: one synchronous write port, three
// combinational read ports, synchronous active-high reset to RST_VAL.
// Ports:
//   clk, reset                 clock / synchronous reset
//   we_i, waddr_i, wdata_i     write port (takes effect at rising edge)
//   raddr_a_i / rdata_a_o      read port A (operand A)
//   raddr_b_i / rdata_b_o      read port B (operand B)
//   raddr_dbg_i / rdata_dbg_o  debug read port
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [1:0] raddr_a_i,
    input  logic [1:0] raddr_b_i,
    input  logic [1:0] raddr_dbg_i,
    output logic [7:0] rdata_a_o,
    output logic [7:0] rdata_b_o,
    output logic [7:0] rdata_dbg_o
);

    logic [REG_WIDTH-1:0] regs_q [REG_COUNT];

    // Reset has priority over a write, so an instruction in flight when
    // reset hits never lands in the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= RST_VAL;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the stored value, so a register being written this cycle
    // still reads its old contents until the next cycle.
    assign rdata_a_o   = regs_q[raddr_a_i];
    assign rdata_b_o   = regs_q[raddr_b_i];
    assign rdata_dbg_o = regs_q[raddr_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Accepts one instruction at a time, drives the external ALU from latched
// operands for one cycle, writes the result back and pulses done.
// IDLE -> EXEC -> WB -> IDLE, one instruction per three cycles.
// Ports:
//   clk, reset                        clock / synchronous active-high reset
//   in_valid / in_ready               instruction handshake
//   in_op, in_rd, in_rs1, in_rs2      opcode and register indices
//   in_use_imm, in_imm, in_shift      operand B select, immediate, shift
//   alu_function_select, alu_shift,
//   alu_a, alu_b                      operands driven to the external ALU
//   alu_f, alu_zero, alu_neg,
//   alu_carry, alu_overflow           result and flags from the ALU
//   done, err                         retire pulse and illegal-op flag
//   status                            {overflow, carry, neg, zero}
//   dbg_addr / dbg_data               debug register read
// ---------------------------------------------------------------------------
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [7:0] REG_RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_op,
    input  logic [1:0] in_rd,
    input  logic [1:0] in_rs1,
    input  logic [1:0] in_rs2,
    input  logic       in_use_imm,
    input  logic [7:0] in_imm,
    input  logic [2:0] in_shift,
    output logic [3:0] alu_function_select,
    output logic [2:0] alu_shift,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_f,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic       done,
    output logic       err,
    output logic [3:0] status,
    input  logic [1:0] dbg_addr,
    output logic [7:0] dbg_data
);

    logic [1:0] state_q, state_d;
    instr_t     instr_q, instr_d;
    logic [3:0] status_q, status_d;

    logic       op_is_alu;
    logic       op_is_loadi;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic [7:0] rs1_data;
    logic [7:0] rs2_data;

    assign op_is_alu   = is_alu_op(instr_q.op);
    assign op_is_loadi = (instr_q.op == OP_LOADI);

    alu_regfile #(
        .RST_VAL(REG_RST_VAL)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .we_i        (reg_we),
        .waddr_i     (instr_q.rd),
        .wdata_i     (reg_wdata),
        .raddr_a_i   (in_rs1),
        .raddr_b_i   (in_rs2),
        .raddr_dbg_i (dbg_addr),
        .rdata_a_o   (rs1_data),
        .rdata_b_o   (rs2_data),
        .rdata_dbg_o (dbg_data)
    );

    // Write-back happens on the EXEC -> WB edge; illegal codes write nothing.
    always_comb begin
        reg_we    = (state_q == ST_EXEC) && (op_is_alu || op_is_loadi);
        reg_wdata = op_is_loadi ? instr_q.imm : alu_f;
    end

    // Next-state logic. Operands are captured at acceptance so a later
    // write to a source register cannot disturb the instruction in flight,
    // and the latches are left alone outside IDLE so the ALU inputs hold.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        status_d = status_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    instr_d.op    = in_op;
                    instr_d.rd    = in_rd;
                    instr_d.shift = in_shift;
                    instr_d.a     = rs1_data;
                    instr_d.b     = in_use_imm ? in_imm : rs2_data;
                    instr_d.imm   = in_imm;
                    state_d       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_is_alu) begin
                    status_d[STATUS_OVF]   = alu_overflow;
                    status_d[STATUS_CARRY] = alu_carry;
                    status_d[STATUS_NEG]   = alu_neg;
                    status_d[STATUS_ZERO]  = alu_zero;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            status_q <= status_d;
        end
    end

    assign in_ready            = (state_q == ST_IDLE);
    assign done                = (state_q == ST_WB);
    assign err                 = done && !(op_is_alu || op_is_loadi);
    assign status              = status_q;
    assign alu_function_select = instr_q.op;
    assign alu_shift           = instr_q.shift;
    assign alu_a               = instr_q.a;
    assign alu_b               = instr_q.b;

endmodule
